// File: rtl/pla_m1_inverse_search.sv
// Sequential inverse lookup for an external combinational PLA.
// Sweeps candidates 0 .. 2**NI-1 through probe_x/probe_z and reports the input
// vectors whose output matches target under mask, in ascending order.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_ready = IDLE)
//   req_target, req_mask       required output word, 1 = compared bit
//   req_all                    0 = first match only, 1 = every match
//   probe_x / probe_z          candidate out to PLA, PLA response back
//   rsp_valid/rsp_ready        response handshake
//   rsp_x, rsp_hit, rsp_last   matching vector, hit flag, final response flag
//   busy                       request in flight
module pla_m1_inverse_search #(
  parameter int unsigned NI = 6,
  parameter int unsigned NO = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [NO-1:0] req_target,
  input  logic [NO-1:0] req_mask,
  input  logic          req_all,
  output logic [NI-1:0] probe_x,
  input  logic [NO-1:0] probe_z,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [NI-1:0] rsp_x,
  output logic          rsp_hit,
  output logic          rsp_last,
  output logic          busy
);

  localparam logic [NI-1:0] CAND_MAX = {NI{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [NI-1:0] r_cand;
  logic [NO-1:0] r_target;
  logic [NO-1:0] r_mask;
  logic          r_all;
  logic [NI-1:0] r_rsp_x;
  logic          r_rsp_hit;
  logic          r_rsp_last;
  logic          r_rsp_valid;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [NI-1:0] w_cand_nxt;
  logic [NO-1:0] w_target_nxt;
  logic [NO-1:0] w_mask_nxt;
  logic          w_all_nxt;
  logic [NI-1:0] w_rsp_x_nxt;
  logic          w_rsp_hit_nxt;
  logic          w_rsp_last_nxt;
  logic          w_match;
  logic          w_cand_is_max;

  // PLA response is combinational on probe_x, so the compare happens in the probe cycle
  assign w_match       = (((probe_z ^ r_target) & r_mask) == '0);
  assign w_cand_is_max = (r_cand == CAND_MAX);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cand      <= '0;
      r_target    <= '0;
      r_mask      <= '0;
      r_all       <= 1'b0;
      r_rsp_x     <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_target    <= w_target_nxt;
      r_mask      <= w_mask_nxt;
      r_all       <= w_all_nxt;
      r_rsp_x     <= w_rsp_x_nxt;
      r_rsp_hit   <= w_rsp_hit_nxt;
      r_rsp_last  <= w_rsp_last_nxt;
      r_rsp_valid <= (w_state_nxt == ST_EMIT);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_cand_nxt     = r_cand;
    w_target_nxt   = r_target;
    w_mask_nxt     = r_mask;
    w_all_nxt      = r_all;
    w_rsp_x_nxt    = r_rsp_x;
    w_rsp_hit_nxt  = r_rsp_hit;
    w_rsp_last_nxt = r_rsp_last;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_target_nxt = req_target;
          w_mask_nxt   = req_mask;
          w_all_nxt    = req_all;
          w_cand_nxt   = '0;
          w_state_nxt  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_match) begin
          w_rsp_x_nxt    = r_cand;
          w_rsp_hit_nxt  = 1'b1;
          w_rsp_last_nxt = !r_all || w_cand_is_max;
          w_state_nxt    = ST_EMIT;
        end else if (!w_cand_is_max) begin
          w_cand_nxt = r_cand + NI'(1);
        end else begin
          // sweep exhausted: terminator response
          w_rsp_x_nxt    = '0;
          w_rsp_hit_nxt  = 1'b0;
          w_rsp_last_nxt = 1'b1;
          w_state_nxt    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rsp_ready) begin
          if (r_rsp_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            // not last implies all-mode below CAND_MAX, so no wrap
            w_cand_nxt  = r_cand + NI'(1);
            w_state_nxt = ST_SCAN;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign probe_x   = r_cand;
  assign rsp_valid = r_rsp_valid;
  assign rsp_x     = r_rsp_x;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_last  = r_rsp_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pla_m1_inverse_search.sv
// Scoreboard bench for pla_m1_inverse_search with a stand-in PLA on probe_x/probe_z.
// Stand-in PLA: x0=1 forces all outputs 0; x=0 gives 0xFE7.
module tb_pla_m1_inverse_search;

  typedef struct packed {
    logic [5:0] x;
    logic       hit;
    logic       last;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_target;
  logic [11:0] req_mask;
  logic        req_all;
  logic [5:0]  probe_x;
  logic [11:0] probe_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_x;
  logic        rsp_hit;
  logic        rsp_last;
  logic        busy;

  int   errors;
  int   checks;
  bit   rnd_ready;
  rsp_t exp_q[$];

  pla_m1_inverse_search #(.NI(6), .NO(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_target(req_target),
    .req_mask  (req_mask),
    .req_all   (req_all),
    .probe_x   (probe_x),
    .probe_z   (probe_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_hit   (rsp_hit),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  function automatic logic [11:0] pla_m1(input logic [5:0] x);
    if (x[0]) return 12'h000;
    return 12'hFE7 ^ (12'(x[5:1]) * 12'h0A5);
  endfunction

  assign probe_z = pla_m1(probe_x);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t mk(input int x, input bit hit, input bit last);
    rsp_t r;
    r.x    = 6'(x);
    r.hit  = hit;
    r.last = last;
    return r;
  endfunction

  // Reference: list every matching input, then shape the response stream by mode
  function automatic int build_expected(input logic [11:0] t, input logic [11:0] m, input logic a);
    int hits[$];
    for (int c = 0; c < 64; c++)
      if (((pla_m1(6'(c)) ^ t) & m) == 12'h000) hits.push_back(c);
    if (hits.size() == 0) begin
      exp_q.push_back(mk(0, 1'b0, 1'b1));
      return 63;
    end
    if (!a) begin
      exp_q.push_back(mk(hits[0], 1'b1, 1'b1));
    end else begin
      foreach (hits[i]) exp_q.push_back(mk(hits[i], 1'b1, hits[i] == 63));
      if (hits[hits.size()-1] != 63) exp_q.push_back(mk(0, 1'b0, 1'b1));
    end
    return hits[0];
  endfunction

  // rsp_ready driver: changes just after each rising edge
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops and compares on every handshake, checks stability while stalled
  initial begin
    bit   stalled;
    rsp_t held;
    rsp_t e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(rsp_valid), 32'd1);
          chk("stall_fields", 32'({rsp_x, rsp_hit, rsp_last}), 32'(held));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got x=%0d hit=%0d last=%0d with no response expected",
                     rsp_x, rsp_hit, rsp_last);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_x_hit_last", 32'({rsp_x, rsp_hit, rsp_last}), 32'(e));
          end
        end
        stalled = rsp_valid && !rsp_ready;
        held    = {rsp_x, rsp_hit, rsp_last};
      end
    end
  end

  task automatic do_req(input logic [11:0] t, input logic [11:0] m, input logic a, input bit rnd);
    int  first_k;
    int  n;
    int  lat;
    bit  seen;
    rnd_ready = rnd;
    first_k = build_expected(t, m, a);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_target = t;
    req_mask   = m;
    req_all    = a;
    @(posedge clk);
    #1;
    // keep req_valid high with junk fields while busy: must be ignored
    req_target = 12'($urandom);
    req_mask   = 12'($urandom);
    req_all    = 1'($urandom);
    n    = 0;
    lat  = 0;
    seen = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
      end
      if (n == 2) req_valid = 1'b0;
      if (!seen && rsp_valid) begin
        seen = 1'b1;
        lat  = n;
      end
      if (n >= 2 && !busy) break;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: still busy after %0d cycles, expected done", n);
    end
    if (seen) chk("first_rsp_latency", 32'(lat), 32'(first_k + 2));
    else begin
      checks++;
      errors++;
      $display("FAIL no_rsp: got no rsp_valid, expected first at cycle T+%0d", first_k + 2);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [5:0]  x;
    logic [11:0] t;
    errors     = 0;
    checks     = 0;
    rnd_ready  = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_target = '0;
    req_mask   = '0;
    req_all    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_probe_x", 32'(probe_x), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_x, rsp_hit, rsp_last}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_req(12'hFE7, 12'hFFF, 1'b0, 1'b0);
    do_req(12'h000, 12'hFFF, 1'b0, 1'b0);
    do_req(12'h000, 12'hFFF, 1'b1, 1'b0);
    do_req(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    do_req(12'h000, 12'h000, 1'b1, 1'b1);
    do_req(12'h000, 12'h000, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      x = 6'($urandom_range(0, 63));
      t = pla_m1(x);
      if ($urandom_range(0, 3) == 0) t = t ^ 12'($urandom);
      do_req(t, 12'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a scan abandons the request
    rnd_ready = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = 12'hFFF;
    req_mask   = 12'hFFF;
    req_all    = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (probe_x != 6'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reached_20", 32'(probe_x), 32'd20);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_probe_x", 32'(probe_x), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(12'hFE7, 12'hFFF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
